nmr_t1_delay_sequencer: RTL



---
 rtl/nmr_t1_delay_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/nmr_t1_delay_sequencer.sv
// Inversion-recovery T1 sequencer: per scan, inversion gate -> T1 delay -> CPMG trigger -> wait for CPMG done.
// Optional macro NMR_T1_IRQ_EN adds the irq output, CTRL bit2 IRQ_ENABLE and CTRL bit3 done-clear.
module nmr_t1_delay_sequencer #(
    parameter int CNT_W  = 32,
    parameter int SCAN_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        inv_gate,
    output logic        cpmg_trig,
    input  logic        cpmg_done,
    output logic        busy
`ifdef NMR_T1_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INV   = 3'd1,
        S_DELAY = 3'd2,
        S_TRIG  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    t1_q, t1_d;
    logic [CNT_W-1:0]    inv_len_q, inv_len_d;
    logic [SCAN_W-1:0]   nscans_q, nscans_d;
    logic [CNT_W-1:0]    t1_sh_q, t1_sh_d;
    logic [CNT_W-1:0]    inv_sh_q, inv_sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic                done_q, done_d;
    logic                inv_gate_q, inv_gate_d;
    logic                trig_q, trig_d;
    logic                busy_q, busy_d;
    logic                irq_en_q, irq_en_d;

    logic wr_en;
    logic ctrl_wr;
    logic start;
    logic abort;

    assign wr_en   = chipselect && !write_n;
    assign ctrl_wr = wr_en && (address == 2'd0);
    assign abort   = ctrl_wr && writedata[1];
    assign start   = ctrl_wr && writedata[0] && !writedata[1];

    always_comb begin
        state_d    = state_q;
        t1_d       = t1_q;
        inv_len_d  = inv_len_q;
        nscans_d   = nscans_q;
        t1_sh_d    = t1_sh_q;
        inv_sh_d   = inv_sh_q;
        cnt_d      = cnt_q;
        scan_cnt_d = scan_cnt_q;
        done_d     = done_q;
        irq_en_d   = irq_en_q;

        if (wr_en) begin
            case (address)
                2'd1:    t1_d      = writedata[CNT_W-1:0];
                2'd2:    inv_len_d = writedata[CNT_W-1:0];
                2'd3:    nscans_d  = writedata[SCAN_W-1:0];
                default: ;
            endcase
        end

`ifdef NMR_T1_IRQ_EN
        if (ctrl_wr) begin
            irq_en_d = writedata[2];
            if (writedata[3]) begin
                done_d = 1'b0;
            end
        end
`else
        irq_en_d = 1'b0;
`endif

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        t1_sh_d    = t1_q;
                        inv_sh_d   = inv_len_q;
                        scan_cnt_d = nscans_q;
                        if (nscans_q == '0) begin
                            done_d = 1'b1;
                        end else begin
                            done_d  = 1'b0;
                            state_d = S_INV;
                            cnt_d   = inv_len_q;
                        end
                    end
                end
                // A loaded length of 0 or 1 both give a single cycle in the phase.
                S_INV: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_DELAY;
                        cnt_d   = t1_sh_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DELAY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_TRIG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_TRIG: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (cpmg_done) begin
                        if (scan_cnt_q <= SCAN_W'(1)) begin
                            scan_cnt_d = '0;
                            state_d    = S_IDLE;
                            done_d     = 1'b1;
                        end else begin
                            scan_cnt_d = scan_cnt_q - SCAN_W'(1);
                            state_d    = S_INV;
                            cnt_d      = inv_sh_q;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        inv_gate_d = (state_d == S_INV);
        trig_d     = (state_d == S_TRIG);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            t1_q       <= '0;
            inv_len_q  <= '0;
            nscans_q   <= '0;
            t1_sh_q    <= '0;
            inv_sh_q   <= '0;
            cnt_q      <= '0;
            scan_cnt_q <= '0;
            done_q     <= 1'b0;
            inv_gate_q <= 1'b0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            t1_q       <= t1_d;
            inv_len_q  <= inv_len_d;
            nscans_q   <= nscans_d;
            t1_sh_q    <= t1_sh_d;
            inv_sh_q   <= inv_sh_d;
            cnt_q      <= cnt_d;
            scan_cnt_q <= scan_cnt_d;
            done_q     <= done_d;
            inv_gate_q <= inv_gate_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            irq_en_q   <= irq_en_d;
        end
    end

    assign inv_gate  = inv_gate_q;
    assign cpmg_trig = trig_q;
    assign busy      = busy_q;

`ifdef NMR_T1_IRQ_EN
    assign irq = done_q && irq_en_q;
`endif

    // With the IRQ option, bit2 holds IRQ_ENABLE, so the state code moves up to bits[7:5].
    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[0] = busy_q;
                readdata[1] = done_q;
`ifdef NMR_T1_IRQ_EN
                readdata[2]   = irq_en_q;
                readdata[7:5] = state_q;
`else
                readdata[4:2] = state_q;
`endif
                readdata[15+SCAN_W:16] = scan_cnt_q;
            end
            2'd1:    readdata[CNT_W-1:0]  = t1_q;
            2'd2:    readdata[CNT_W-1:0]  = inv_len_q;
            default: readdata[SCAN_W-1:0] = nscans_q;
        endcase
    end

endmodule
